// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: writeback/data-source selects,
// opcode and load funct3 values, and the WB pipeline control record.
package wb_stage_pkg;

    // Writeback value select (code 3 behaves as WB_ALU)
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Load data source select (any code other than D_UART reads DMEM)
    localparam logic [1:0] D_DMEM = 2'd0;
    localparam logic [1:0] D_UART = 2'd1;

    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_IMM  = 7'h13;
    localparam logic [6:0] OP_JAL  = 7'h6f;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } load_f3_e;

    // Control half of the MEM/WB register
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [1:0]  wbsel;
        logic [1:0]  dsel;
        logic        regwen;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage to WB-stage bundle plus the regfile write port, forwarding bus
// and retired-instruction count. master = pipeline side, slave = wb_stage.
interface wb_stage_if #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 32
);
    logic                 stall;
    logic                 flush;
    logic                 mem_valid;
    logic [31:0]          mem_inst;
    logic [XLEN-1:0]      mem_alu;
    logic [XLEN-1:0]      mem_pc4;
    logic [1:0]           mem_wbsel;
    logic [1:0]           mem_dsel;
    logic                 mem_regwen;
    logic [31:0]          dmem_rdata;
    logic [31:0]          uart_rdata;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 fwd_valid;
    logic [4:0]           fwd_rd;
    logic [XLEN-1:0]      fwd_data;
    logic [INSTRET_W-1:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_inst, mem_alu, mem_pc4,
               mem_wbsel, mem_dsel, mem_regwen, dmem_rdata, uart_rdata,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_inst, mem_alu, mem_pc4,
               mem_wbsel, mem_dsel, mem_regwen, dmem_rdata, uart_rdata,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, instret
    );

endinterface

// File: rtl/wb_stage_load_extend.sv
// Load formatter: picks the byte/halfword addressed by the low address bits
// out of a raw 32-bit word and sign- or zero-extends it. Unknown funct3
// codes pass the whole word through.
module wb_stage_load_extend
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     raw,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection; halfword loads ignore offset[0]
    always_comb begin
        byte_sel = raw[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? raw[31:16] : raw[15:0];
    end

    // Extension by load type
    always_comb begin
        data = XLEN'($signed(raw));
        case (funct3)
            F3_LB:   data = XLEN'($signed(byte_sel));
            F3_LBU:  data = XLEN'(byte_sel);
            F3_LH:   data = XLEN'($signed(half_sel));
            F3_LHU:  data = XLEN'(half_sel);
            default: data = XLEN'($signed(raw));
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath. Load data is taken from
// the memory read ports in the WB cycle; the first stalled cycle snapshots
// it so the written value cannot drift while memory outputs change.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    wb_ctrl_t              ctrl;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       pc4;
    logic                  hold_valid;
    logic [31:0]           hold_data;
    logic [INSTRET_W-1:0]  instret_q;

    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic                  pending;
    logic                  retire;
    logic [31:0]           src_word;
    logic [31:0]           raw_word;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       wdata;
    logic                  unused_inst_bits;

    assign rd               = ctrl.inst[11:7];
    assign funct3           = ctrl.inst[14:12];
    assign unused_inst_bits = ^{ctrl.inst[31:15], ctrl.inst[6:0]};

    // MEM/WB register: stall holds (and masks flush), flush inserts a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
            alu  <= '0;
            pc4  <= '0;
        end else if (!bus.stall) begin
            if (bus.flush) begin
                ctrl.valid <= 1'b0;
            end else begin
                ctrl.valid  <= bus.mem_valid;
                ctrl.inst   <= bus.mem_inst;
                ctrl.wbsel  <= bus.mem_wbsel;
                ctrl.dsel   <= bus.mem_dsel;
                ctrl.regwen <= bus.mem_regwen;
                alu         <= bus.mem_alu;
                pc4         <= bus.mem_pc4;
            end
        end
    end

    // Snapshot the load source on the first stalled cycle; release on any unstalled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (!bus.stall) begin
            hold_valid <= 1'b0;
        end else if (ctrl.valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= src_word;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Source select and writeback value
    always_comb begin
        src_word = (ctrl.dsel == D_UART) ? bus.uart_rdata : bus.dmem_rdata;
        raw_word = hold_valid ? hold_data : src_word;
        case (ctrl.wbsel)
            WB_MEM:  wdata = load_data;
            WB_PC4:  wdata = pc4;
            default: wdata = alu;
        endcase
    end

    wb_stage_load_extend #(.XLEN(XLEN)) u_load_extend (
        .raw    (raw_word),
        .offset (alu[1:0]),
        .funct3 (funct3),
        .data   (load_data)
    );

    assign pending = ctrl.valid & ctrl.regwen & (rd != 5'd0);
    assign retire  = ctrl.valid & ~bus.stall;

    assign bus.rf_we     = pending & ~bus.stall;
    assign bus.rf_waddr  = rd;
    assign bus.rf_wdata  = wdata;
    assign bus.fwd_valid = pending;
    assign bus.fwd_rd    = rd;
    assign bus.fwd_data  = wdata;
    assign bus.instret   = instret_q;

endmodule
